// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and selectable registered or fall-through read.
module fifo_sync_param #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_TH  = DEPTH - 2,
  parameter  int AEMPTY_TH = 2,
  parameter  int FWFT      = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C     = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_C     = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             rd_ok, wr_ok;

  // Flags decode straight from the count register, so no wen/ren -> output path.
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign afull  = (count >= AF_C);
  assign aempty = (count <= AE_C);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_ok = ren && !empty;
  assign wr_ok = wen && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Set dominates a simultaneous clear.
      overflow  <= (wen && !wr_ok) || (overflow && !err_clr);
      underflow <= (ren && empty)  || (underflow && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata  = mem[rptr];
      assign rvalid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_ok;
          if (rd_ok) rdata_q <= mem[rptr];
        end
      end
      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule
